// File: rtl/matmul_engine_if.sv
// Bus bundle for matmul_engine: job control, dimension overrides, A/B read ports,
// C write port and status. The slave modport is the engine side.
interface matmul_engine_if;
  logic        start;
  logic        ready;
  logic        override_dims;
  logic [31:0] ovr_a_dims;
  logic [31:0] ovr_b_dims;
  logic [15:0] a_base;
  logic [15:0] b_base;
  logic [15:0] c_base;
  logic [15:0] a_rd_addr;
  logic [31:0] a_rd_data;
  logic [15:0] b_rd_addr;
  logic [31:0] b_rd_data;
  logic        c_wr_en;
  logic [15:0] c_wr_addr;
  logic [31:0] c_wr_data;
  logic [15:0] dim_m;
  logic [15:0] dim_k;
  logic [15:0] dim_n;
  logic        dim_err;

  modport master (
    output start, override_dims, ovr_a_dims, ovr_b_dims, a_base, b_base, c_base,
           a_rd_data, b_rd_data,
    input  ready, a_rd_addr, b_rd_addr, c_wr_en, c_wr_addr, c_wr_data,
           dim_m, dim_k, dim_n, dim_err
  );

  modport slave (
    input  start, override_dims, ovr_a_dims, ovr_b_dims, a_base, b_base, c_base,
           a_rd_data, b_rd_data,
    output ready, a_rd_addr, b_rd_addr, c_wr_en, c_wr_addr, c_wr_data,
           dim_m, dim_k, dim_n, dim_err
  );
endinterface

// File: rtl/matmul_engine.sv
// Sequential matrix multiplier: one multiply-accumulate per cycle over K, one C write
// per output element, with A row-major and B column-major in synchronous SRAMs.
module matmul_engine (
  input  logic            clk,
  input  logic            reset_n,
  matmul_engine_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, DIMS_RD, DIMS_CAP, MAC, DRAIN, WRITE} state_e;

  state_e      state_q, state_d;
  logic [15:0] k_q, k_d, i_q, i_d, j_q, j_d;
  logic [15:0] a_row_q, a_row_d;     // address of A(i,0)
  logic [15:0] b_col_q, b_col_d;     // address of B(0,j)
  logic [15:0] b_first_q, b_first_d; // address of B(0,0)
  logic [15:0] c_ptr_q, c_ptr_d;     // address of the next C write
  logic [31:0] acc_q, acc_d;
  logic [15:0] a_rd_addr_q, a_rd_addr_d, b_rd_addr_q, b_rd_addr_d;
  logic        c_wr_en_q, c_wr_en_d;
  logic [15:0] c_wr_addr_q, c_wr_addr_d;
  logic [31:0] c_wr_data_q, c_wr_data_d;
  logic [15:0] dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;
  logic        dim_err_q, dim_err_d;
  logic [31:0] prod;

  // Low 32 bits of a product are the same for signed and unsigned operands.
  assign prod = bus.a_rd_data * bus.b_rd_data;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    k_d         = k_q;
    i_d         = i_q;
    j_d         = j_q;
    a_row_d     = a_row_q;
    b_col_d     = b_col_q;
    b_first_d   = b_first_q;
    c_ptr_d     = c_ptr_q;
    acc_d       = acc_q;
    a_rd_addr_d = a_rd_addr_q;
    b_rd_addr_d = b_rd_addr_q;
    c_wr_en_d   = 1'b0;
    c_wr_addr_d = c_wr_addr_q;
    c_wr_data_d = c_wr_data_q;
    dim_m_d     = dim_m_q;
    dim_k_d     = dim_k_q;
    dim_n_d     = dim_n_q;
    dim_err_d   = dim_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dim_err_d   = 1'b0;
          c_ptr_d     = bus.c_base;
          i_d         = '0;
          j_d         = '0;
          k_d         = '0;
          a_rd_addr_d = bus.a_base;
          b_rd_addr_d = bus.b_base;
          if (bus.override_dims) begin
            dim_m_d   = bus.ovr_a_dims[31:16];
            dim_k_d   = bus.ovr_a_dims[15:0];
            dim_n_d   = bus.ovr_b_dims[15:0];
            dim_err_d = bus.ovr_a_dims[15:0] != bus.ovr_b_dims[31:16];
            a_row_d   = bus.a_base;
            b_col_d   = bus.b_base;
            b_first_d = bus.b_base;
            // An empty override job has nothing to do, so it never leaves IDLE.
            if (bus.ovr_a_dims[31:16] != '0 && bus.ovr_a_dims[15:0] != '0 &&
                bus.ovr_b_dims[15:0] != '0)
              state_d = MAC;
          end else begin
            // Word 0 of each region is the dimension word; data follows it.
            a_row_d   = bus.a_base + 16'd1;
            b_col_d   = bus.b_base + 16'd1;
            b_first_d = bus.b_base + 16'd1;
            state_d   = DIMS_RD;
          end
        end
      end
      DIMS_RD: state_d = DIMS_CAP;
      DIMS_CAP: begin
        dim_m_d   = bus.a_rd_data[31:16];
        dim_k_d   = bus.a_rd_data[15:0];
        dim_n_d   = bus.b_rd_data[15:0];
        dim_err_d = bus.a_rd_data[15:0] != bus.b_rd_data[31:16];
        if (bus.a_rd_data[31:16] == '0 || bus.a_rd_data[15:0] == '0 ||
            bus.b_rd_data[15:0] == '0) begin
          state_d = IDLE;
        end else begin
          a_rd_addr_d = a_row_q;
          b_rd_addr_d = b_col_q;
          state_d     = MAC;
        end
      end
      MAC: begin
        // Read data lags the address by one cycle, so k=0 sees no valid product.
        acc_d = (k_q == '0) ? '0 : acc_q + prod;
        if (k_q == dim_k_q - 16'd1) begin
          state_d = DRAIN;
        end else begin
          k_d         = k_q + 16'd1;
          a_rd_addr_d = a_rd_addr_q + 16'd1;
          b_rd_addr_d = b_rd_addr_q + 16'd1;
        end
      end
      DRAIN: begin
        c_wr_en_d   = 1'b1;
        c_wr_data_d = acc_q + prod;
        c_wr_addr_d = c_ptr_q;
        c_ptr_d     = c_ptr_q + 16'd1;
        state_d     = WRITE;
      end
      WRITE: begin
        k_d = '0;
        if (j_q == dim_n_q - 16'd1 && i_q == dim_m_q - 16'd1) begin
          state_d = IDLE;
        end else begin
          if (j_q == dim_n_q - 16'd1) begin
            i_d     = i_q + 16'd1;
            j_d     = '0;
            a_row_d = a_row_q + dim_k_q;
            b_col_d = b_first_q;
          end else begin
            j_d     = j_q + 16'd1;
            b_col_d = b_col_q + dim_k_q;
          end
          a_rd_addr_d = a_row_d;
          b_rd_addr_d = b_col_d;
          state_d     = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      a_row_q     <= '0;
      b_col_q     <= '0;
      b_first_q   <= '0;
      c_ptr_q     <= '0;
      acc_q       <= '0;
      a_rd_addr_q <= '0;
      b_rd_addr_q <= '0;
      c_wr_en_q   <= 1'b0;
      c_wr_addr_q <= '0;
      c_wr_data_q <= '0;
      dim_m_q     <= '0;
      dim_k_q     <= '0;
      dim_n_q     <= '0;
      dim_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      i_q         <= i_d;
      j_q         <= j_d;
      a_row_q     <= a_row_d;
      b_col_q     <= b_col_d;
      b_first_q   <= b_first_d;
      c_ptr_q     <= c_ptr_d;
      acc_q       <= acc_d;
      a_rd_addr_q <= a_rd_addr_d;
      b_rd_addr_q <= b_rd_addr_d;
      c_wr_en_q   <= c_wr_en_d;
      c_wr_addr_q <= c_wr_addr_d;
      c_wr_data_q <= c_wr_data_d;
      dim_m_q     <= dim_m_d;
      dim_k_q     <= dim_k_d;
      dim_n_q     <= dim_n_d;
      dim_err_q   <= dim_err_d;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.a_rd_addr = a_rd_addr_q;
  assign bus.b_rd_addr = b_rd_addr_q;
  assign bus.c_wr_en   = c_wr_en_q;
  assign bus.c_wr_addr = c_wr_addr_q;
  assign bus.c_wr_data = c_wr_data_q;
  assign bus.dim_m     = dim_m_q;
  assign bus.dim_k     = dim_k_q;
  assign bus.dim_n     = dim_n_q;
  assign bus.dim_err   = dim_err_q;

endmodule
